// File: rtl/id_regfile.sv
// Decode-stage register file with optional WB-to-ID bypass and the ID/EX pipeline register.
// Define ID_REGFILE_BYPASS_EN to honour ForwardID_A/B; otherwise operands come from storage only.
module id_regfile #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWrite_W,
  input  logic [4:0]      rd_W,
  input  logic [XLEN-1:0] Result_W,
  input  logic [31:0]     Ins_D,
  input  logic            ForwardID_A,
  input  logic            ForwardID_B,
  input  logic            Stall_E,
  input  logic            Flush_E,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [4:0]      rs1_E,
  output logic [4:0]      rs2_E,
  output logic [4:0]      rd_E
);

  logic [XLEN-1:0] regs_q [32];

  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0] rf1, rf2;
  logic [XLEN-1:0] op1, op2;

  logic [XLEN-1:0] rd1_q, rd2_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;

  assign rs1_d = Ins_D[19:15];
  assign rs2_d = Ins_D[24:20];
  assign rd_d  = Ins_D[11:7];

  // Opcode/funct bits are decoded elsewhere.
  logic unused_ins;
  assign unused_ins = ^{Ins_D[31:25], Ins_D[14:12], Ins_D[6:0]};

  // x0 is never written, but force zero on read so it is independent of storage.
  assign rf1 = (rs1_d == 5'd0) ? '0 : regs_q[rs1_d];
  assign rf2 = (rs2_d == 5'd0) ? '0 : regs_q[rs2_d];

`ifdef ID_REGFILE_BYPASS_EN
  assign op1 = ForwardID_A ? Result_W : rf1;
  assign op2 = ForwardID_B ? Result_W : rf2;
`else
  logic unused_fwd;
  assign unused_fwd = ForwardID_A ^ ForwardID_B;
  assign op1 = rf1;
  assign op2 = rf2;
`endif

  // Storage writes are independent of Stall_E/Flush_E; reset drops a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (RegWrite_W && (rd_W != 5'd0)) begin
      regs_q[rd_W] <= Result_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || Flush_E) begin
      rd1_q <= '0;
      rd2_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
    end else if (!Stall_E) begin
      rd1_q <= op1;
      rd2_q <= op2;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      rd_q  <= rd_d;
    end
  end

  assign RD1_E = rd1_q;
  assign RD2_E = rd2_q;
  assign rs1_E = rs1_q;
  assign rs2_E = rs2_q;
  assign rd_E  = rd_q;

endmodule

// File: doc/id_regfile.md
ID_REGFILE -- requirements
Module: id_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width of registers, Result_W, RD1_E and RD2_E.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port RegWrite_W  input  1  writeback-stage register write enable.
REQ-005 SHALL have port rd_W  input  5  writeback destination register index.
REQ-006 SHALL have port Result_W  input  XLEN  writeback data.
REQ-007 SHALL have port Ins_D  input  32  decode-stage instruction; rs1 = Ins_D[19:15], rs2 = Ins_D[24:20], rd = Ins_D[11:7].
REQ-008 SHALL have ports ForwardID_A / ForwardID_B  input  1 each  WB-to-ID bypass selects for rs1 / rs2 from the ID hazard unit.
REQ-009 SHALL have port Stall_E  input  1  hold ID/EX outputs.
REQ-010 SHALL have port Flush_E  input  1  load a bubble into ID/EX outputs.
REQ-011 SHALL have ports RD1_E / RD2_E  output  XLEN each  registered rs1 / rs2 operand data to EX.
REQ-012 SHALL have ports rs1_E, rs2_E, rd_E  output  5 each  registered register indices to EX.

Function
REQ-013 SHALL hold 32 XLEN-bit registers; x0 reads as 0 always; writes to x0 SHALL be discarded.
REQ-014 SHALL write Result_W into register rd_W at the rising edge when RegWrite_W=1 and rd_W!=0, regardless of Stall_E/Flush_E.
REQ-015 SHALL form decode operands combinationally: op1 = Result_W if ForwardID_A=1 else reg[rs1]; op2 likewise with ForwardID_B/rs2.
REQ-016 SHALL update ID/EX outputs each rising edge with priority rst > Flush_E > Stall_E > capture.
REQ-017 Capture SHALL load RD1_E=op1, RD2_E=op2, rs1_E/rs2_E/rd_E from Ins_D fields; latency 1 cycle from Ins_D to E outputs.
REQ-018 Flush SHALL load all E outputs with 0 (bubble: rd_E=0 never writes); Flush_E and Stall_E together SHALL flush.
REQ-019 Stall SHALL hold all E outputs unchanged; a WB write to a held source register SHALL NOT refresh RD1_E/RD2_E (EX forwarding covers it).
REQ-020 Same-cycle write and read of the same register without ForwardID asserted SHALL return the old stored value (no implicit bypass).
REQ-021 ForwardID_A/B asserted with rs=0 SHALL still yield the selected value; hazard unit guarantees this does not occur, no extra masking.

Reset
REQ-022 With rst=1 at a rising edge, all 32 registers and all E outputs SHALL become 0; pending WB write in that cycle SHALL be discarded.
REQ-023 rst asserted mid-stall or mid-flush SHALL override both; first capture occurs on the first edge with rst=0.

Configuration
REQ-024 Macro ID_REGFILE_BYPASS_EN: defined -> REQ-015 bypass active; undefined -> ForwardID_A/B ports remain but are ignored, op1/op2 always from storage (WB-to-ID hazard then needs a stall upstream).

Verification
REQ-025 Reset: rst=1 one edge with RegWrite_W=1, rd_W=5, Result_W=0xDEAD -> reg x5 and all E outputs read 0.
REQ-026 Write then read: write x3=0x1234 at cycle 0; cycle 1 Ins_D rs1=3, rs2=0 -> cycle 2 RD1_E=0x1234, RD2_E=0.
REQ-027 Bypass (macro defined): same cycle write x7=0xCAFE, Ins_D rs1=7, ForwardID_A=1 -> next edge RD1_E=0xCAFE; macro undefined -> RD1_E=old x7 value.
REQ-028 x0 write: RegWrite_W=1, rd_W=0, Result_W=0xFFFF_FFFF -> subsequent rs1=0 read gives RD1_E=0.
REQ-029 Stall/flush: capture rd_E=9, then Stall_E=1 two cycles with new Ins_D -> rd_E stays 9; Stall_E=1 and Flush_E=1 -> all E outputs 0; WB write x2=0x55 during stall lands (later read 0x55).
